uart_tx_frame: RTL and testbench

Parametrised UART serial transmitter, successor to the team's fixed 8N1 transmitter.
- Configurable at elaboration: data width, stop-bit count, bit period.
- Runtime parity selection per frame.
- One-entry holding register, so a producer (e.g. a TX FIFO) can queue the next byte during a transmission and frames go out back-to-back with no idle gap.
- Sits between the TX FIFO and the pad-level `tx` line in the UART subsystem.

---
 rtl/uart_pkg.sv | 35 +++
 rtl/uart_bit_timer.sv | 38 +++
 rtl/uart_tx_frame.sv | 162 ++++++++++++++++
 tb/tb_uart_tx_frame.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, parity codes and parity helper for the UART blocks
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // Widest frame payload any UART block in the subsystem supports.
    localparam int MAX_DATA_BITS = 9;

    // Data narrower than MAX_DATA_BITS is zero-extended by the caller; the
    // extra zeros do not change the XOR.
    function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                        input logic [1:0]               code);
        case (code)
            PAR_EVEN: return ^data;
            PAR_ODD:  return ~(^data);
            default:  return 1'b0;
        endcase
    endfunction

    // Code 2'b11 behaves as "no parity".
    function automatic logic parity_enabled(input logic [1:0] code);
        return (code == PAR_EVEN) || (code == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - bit-period tick counter with clear and multi-period terminal count
//
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   clear       holds the counter at zero while high
//   periods     number of bit periods (1..MAX_PERIODS) before done fires
//   done        high on the last clock of the requested span; counter
//               restarts from zero on the following clock
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 40,
    parameter int MAX_PERIODS  = 1,
    parameter int CNT_W        = $clog2(MAX_PERIODS * CLKS_PER_BIT),
    parameter int PER_W        = $clog2(MAX_PERIODS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [PER_W-1:0] periods,
    output logic             done
);

    logic [CNT_W-1:0] count;
    logic [31:0]      terminal;

    assign terminal = 32'(periods) * 32'(CLKS_PER_BIT) - 32'd1;
    assign done     = (32'(count) == terminal);

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            count <= '0;
        end else if (done) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - parametrised UART transmitter with runtime parity and one-entry holding register
//
// Ports:
//   clk, rst_n    clock and synchronous active-low reset
//   tx_start      write strobe, taken only while tx_ready is high
//   din           frame data, sent LSB first
//   parity_sel    00 none, 01 even, 10 odd, 11 none; latched with din
//   tx_ready      holding register empty
//   tx_busy       a frame is on the line
//   tx            registered serial output, idle high
//   tx_done_tick  one-cycle pulse during the last stop-bit clock
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 40,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] din,
    input  logic [1:0]           parity_sel,
    output logic                 tx_ready,
    output logic                 tx_busy,
    output logic                 tx,
    output logic                 tx_done_tick
);

    localparam int IDX_W = $clog2(DATA_BITS);
    localparam int PER_W = $clog2(STOP_BITS + 1);

    uart_state_t state, state_next;

    logic                 hold_valid;
    logic [DATA_BITS-1:0] hold_data;
    logic [1:0]           hold_par;
    logic [DATA_BITS-1:0] shift_data;
    logic [1:0]           shift_par;
    logic [IDX_W-1:0]     bit_idx;

    logic             t_done;
    logic [PER_W-1:0] periods;
    logic             load_shift;
    logic             frame_end;
    logic             tx_next;
    logic             last_bit;
    logic             par_value;

    assign tx_ready  = !hold_valid;
    assign last_bit  = (bit_idx == IDX_W'(DATA_BITS - 1));
    assign par_value = parity_bit(MAX_DATA_BITS'(shift_data), shift_par);
    assign periods   = (state == STOP) ? PER_W'(STOP_BITS) : PER_W'(1);

    // Only STOP spans more than one bit period; every other state change
    // happens on a timer done, which already restarts the count.
    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .MAX_PERIODS  (STOP_BITS)
    ) u_bit_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state == IDLE),
        .periods (periods),
        .done    (t_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // tx_next is derived from the current state and registered, so the line
    // trails the state register by one clock.
    always_comb begin
        state_next = state;
        load_shift = 1'b0;
        frame_end  = 1'b0;
        tx_next    = 1'b1;
        case (state)
            IDLE: begin
                if (hold_valid) begin
                    state_next = START;
                    load_shift = 1'b1;
                end
            end
            START: begin
                tx_next = 1'b0;
                if (t_done) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                tx_next = shift_data[bit_idx];
                if (t_done && last_bit) begin
                    state_next = parity_enabled(shift_par) ? PARITY : STOP;
                end
            end
            PARITY: begin
                tx_next = par_value;
                if (t_done) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (t_done) begin
                    frame_end = 1'b1;
                    // A queued frame chains straight into its start bit.
                    if (hold_valid) begin
                        state_next = START;
                        load_shift = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_valid   <= 1'b0;
            hold_data    <= '0;
            hold_par     <= PAR_NONE;
            shift_data   <= '0;
            shift_par    <= PAR_NONE;
            bit_idx      <= '0;
            tx           <= 1'b1;
            tx_busy      <= 1'b0;
            tx_done_tick <= 1'b0;
        end else begin
            tx           <= tx_next;
            tx_busy      <= (state != IDLE);
            tx_done_tick <= frame_end;

            // load_shift needs hold_valid=1 and a write needs hold_valid=0,
            // so the two never collide.
            if (load_shift) begin
                hold_valid <= 1'b0;
                shift_data <= hold_data;
                shift_par  <= hold_par;
            end else if (tx_start && !hold_valid) begin
                hold_valid <= 1'b1;
                hold_data  <= din;
                hold_par   <= parity_sel;
            end

            if (state != DATA) begin
                bit_idx <= '0;
            end else if (t_done) begin
                bit_idx <= bit_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb/tb_uart_tx_frame.sv - directed self-checking bench for uart_tx_frame
module tb_uart_tx_frame;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic       a_start;
    logic [7:0] a_din;
    logic [1:0] a_par;
    logic       a_ready, a_busy, a_tx, a_done;

    logic       b_start;
    logic [6:0] b_din;
    logic [1:0] b_par;
    logic       b_ready, b_busy, b_tx, b_done;

    int n_cmp  = 0;
    int n_fail = 0;

    uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_BITS(1)) u_dut_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .tx_start     (a_start),
        .din          (a_din),
        .parity_sel   (a_par),
        .tx_ready     (a_ready),
        .tx_busy      (a_busy),
        .tx           (a_tx),
        .tx_done_tick (a_done)
    );

    uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(7), .STOP_BITS(2)) u_dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .tx_start     (b_start),
        .din          (b_din),
        .parity_sel   (b_par),
        .tx_ready     (b_ready),
        .tx_busy      (b_busy),
        .tx           (b_tx),
        .tx_done_tick (b_done)
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Called at a negedge; leaves the bench at the negedge just before the
    // start bit appears on the line.
    task automatic write(input bit sel_b, input logic [7:0] d, input logic [1:0] p,
                         input string tag);
        if (sel_b) begin
            b_start = 1'b1; b_din = d[6:0]; b_par = p;
        end else begin
            a_start = 1'b1; a_din = d; a_par = p;
        end
        @(negedge clk);
        a_start = 1'b0; b_start = 1'b0;
        check({tag, " ready after write"}, sel_b ? b_ready : a_ready, 1'b0);
        check({tag, " tx idle w1"},        sel_b ? b_tx    : a_tx,    1'b1);
        @(negedge clk);
        check({tag, " ready refilled"},    sel_b ? b_ready : a_ready, 1'b1);
        check({tag, " tx idle w2"},        sel_b ? b_tx    : a_tx,    1'b1);
        check({tag, " busy before start"}, sel_b ? b_busy  : a_busy,  1'b0);
    endtask

    // bits[0] is the start bit; one sample per clock, 4 clocks per bit.
    task automatic check_frame(input bit sel_b, input logic [15:0] bits, input int nbits,
                               input int poke_at, input logic [7:0] poke_din,
                               input logic [1:0] poke_par, input logic poke_ready,
                               input string tag);
        for (int i = 0; i < nbits * 4; i++) begin
            @(negedge clk);
            a_start = 1'b0; b_start = 1'b0;
            check($sformatf("%s tx c%0d", tag, i + 1),   sel_b ? b_tx   : a_tx,   bits[i / 4]);
            check($sformatf("%s done c%0d", tag, i + 1), sel_b ? b_done : a_done, (i == nbits * 4 - 1));
            check($sformatf("%s busy c%0d", tag, i + 1), sel_b ? b_busy : a_busy, 1'b1);
            if (i == poke_at) begin
                check($sformatf("%s ready at poke", tag), sel_b ? b_ready : a_ready, poke_ready);
                if (sel_b) begin
                    b_start = 1'b1; b_din = poke_din[6:0]; b_par = poke_par;
                end else begin
                    a_start = 1'b1; a_din = poke_din; a_par = poke_par;
                end
            end
        end
    endtask

    task automatic check_idle(input bit sel_b, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check($sformatf("%s idle tx %0d", tag, i),    sel_b ? b_tx    : a_tx,    1'b1);
            check($sformatf("%s idle busy %0d", tag, i),  sel_b ? b_busy  : a_busy,  1'b0);
            check($sformatf("%s idle done %0d", tag, i),  sel_b ? b_done  : a_done,  1'b0);
            check($sformatf("%s idle ready %0d", tag, i), sel_b ? b_ready : a_ready, 1'b1);
        end
    endtask

    initial begin
        logic [15:0] abort_bits;

        rst_n   = 1'b0;
        a_start = 1'b0; a_din = 8'h00; a_par = 2'b00;
        b_start = 1'b0; b_din = 7'h00; b_par = 2'b00;
        @(negedge clk);
        @(negedge clk);
        check("reset tx a", a_tx, 1'b1);
        check("reset busy a", a_busy, 1'b0);
        check("reset ready a", a_ready, 1'b1);
        check("reset done a", a_done, 1'b0);
        check("reset tx b", b_tx, 1'b1);
        check("reset ready b", b_ready, 1'b1);
        rst_n = 1'b1;
        check_idle(1'b0, 2, "post reset");

        // 8N1, 0xA5: line 0,1,0,1,0,0,1,0,1,1
        write(1'b0, 8'hA5, 2'b00, "a5");
        check_frame(1'b0, {6'd0, 1'b1, 8'hA5, 1'b0}, 10, -1, 8'h00, 2'b00, 1'b0, "a5");
        check_idle(1'b0, 2, "a5");

        // 0x07 has three ones: even parity bit 1, odd parity bit 0
        write(1'b0, 8'h07, 2'b01, "even07");
        check_frame(1'b0, {5'd0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, -1, 8'h00, 2'b00, 1'b0, "even07");
        check_idle(1'b0, 2, "even07");

        write(1'b0, 8'h07, 2'b10, "odd07");
        check_frame(1'b0, {5'd0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, -1, 8'h00, 2'b00, 1'b0, "odd07");
        check_idle(1'b0, 2, "odd07");

        // 7 data bits, odd parity of zero is 1, two stop bits
        write(1'b1, 8'h00, 2'b10, "b7o2");
        check_frame(1'b1, {5'd0, 2'b11, 1'b1, 7'h00, 1'b0}, 11, -1, 8'h00, 2'b00, 1'b0, "b7o2");
        check_idle(1'b1, 2, "b7o2");

        // Back-to-back: 0x22 queued as soon as 0x11 leaves the holding
        // register; 0x33 offered while the register is full must be dropped.
        write(1'b0, 8'h11, 2'b00, "b2b");
        a_start = 1'b1; a_din = 8'h22; a_par = 2'b00;
        check_frame(1'b0, {6'd0, 1'b1, 8'h11, 1'b0}, 10, 10, 8'h33, 2'b00, 1'b0, "b2b first");
        check_frame(1'b0, {6'd0, 1'b1, 8'h22, 1'b0}, 10, -1, 8'h00, 2'b00, 1'b0, "b2b second");
        check_idle(1'b0, 8, "b2b");

        // Write on the final STOP clock with the register empty: one extra
        // idle-high clock, then 0xC3 (four ones, even parity 0).
        write(1'b0, 8'h5A, 2'b00, "eos");
        check_frame(1'b0, {6'd0, 1'b1, 8'h5A, 1'b0}, 10, 38, 8'hC3, 2'b01, 1'b1, "eos first");
        check_idle(1'b0, 1, "eos gap");
        check_frame(1'b0, {5'd0, 1'b1, 1'b0, 8'hC3, 1'b0}, 11, -1, 8'h00, 2'b00, 1'b0, "eos second");
        check_idle(1'b0, 2, "eos");

        // Reset during data bit 3 (line clocks 17..20)
        abort_bits = {6'd0, 1'b1, 8'hA5, 1'b0};
        write(1'b0, 8'hA5, 2'b00, "abort");
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            check($sformatf("abort tx c%0d", i + 1), a_tx, abort_bits[i / 4]);
            check($sformatf("abort done c%0d", i + 1), a_done, 1'b0);
        end
        rst_n = 1'b0;
        @(negedge clk);
        check("abort tx after reset", a_tx, 1'b1);
        check("abort busy after reset", a_busy, 1'b0);
        check("abort ready after reset", a_ready, 1'b1);
        check("abort done after reset", a_done, 1'b0);
        rst_n = 1'b1;
        check_idle(1'b0, 4, "abort");

        // 0x3C has four ones: even parity bit 0
        write(1'b0, 8'h3C, 2'b01, "clean");
        check_frame(1'b0, {5'd0, 1'b1, 1'b0, 8'h3C, 1'b0}, 11, -1, 8'h00, 2'b00, 1'b0, "clean");
        check_idle(1'b0, 2, "clean");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
